// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// The FSM state encoding and the bit-counter width live here so every file agrees on them.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Bits needed to count WIDTH-1 down to 0; WIDTH is at least 2, so this is never below 1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it stays non-negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_prem,
    output logic             o_q_bit
);
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    // One spare bit above the shifted value keeps the borrow visible as the sign.
    assign w_shifted = {i_prem, i_bit};
    assign w_diff    = w_shifted - {2'b00, i_dvs};
    assign w_neg     = w_diff[WIDTH+1];

    assign o_q_bit = ~w_neg;
    assign o_prem  = w_neg ? w_shifted[WIDTH:0] : w_diff[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, unsigned or two's-complement signed, one quotient bit per clock.
// Magnitudes are divided and the signs are applied to the results on the final iteration.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;

    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dq;       // dividend bits shift out of the top, quotient bits shift in below
    logic [WIDTH-1:0] r_dvs_mag;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_prem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_last     = (r_cnt == '0);
    assign w_dvs_zero = (divisor == '0);
    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_prem  (r_prem),
        .i_bit   (r_dq[WIDTH-1]),
        .i_dvs   (r_dvs_mag),
        .o_prem  (w_prem_next),
        .o_q_bit (w_q_bit)
    );

    // Most-negative / -1 yields magnitude 2^(WIDTH-1), which already reads back as the most-negative value.
    assign w_q_mag = {r_dq[WIDTH-2:0], w_q_bit};
    assign w_r_mag = w_prem_next[WIDTH-1:0];
    assign w_q_fix = r_q_neg ? (~w_q_mag + 1'b1) : w_q_mag;
    assign w_r_fix = r_r_neg ? (~w_r_mag + 1'b1) : w_r_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CALC;
            CALC:    if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A zero divisor still spends a single CALC pass so done lands one cycle after the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prem        <= '0;
            r_dq          <= '0;
            r_dvs_mag     <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dz          <= 1'b0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_prem        <= '0;
            r_dvs_mag     <= w_dvs_mag;
            r_q_neg       <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg       <= w_dvd_neg;
            r_dz          <= w_dvs_zero;
            r_dq          <= w_dvs_zero ? dividend : w_dvd_mag;
            r_cnt         <= w_dvs_zero ? '0 : CNT_LAST;
            r_div_by_zero <= 1'b0;
        end else if (r_state == CALC) begin
            r_prem <= w_prem_next;
            r_dq   <= w_q_mag;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
                if (r_dz) begin
                    r_quotient    <= '1;
                    r_remainder   <= r_dq;
                    r_div_by_zero <= 1'b1;
                end else begin
                    r_quotient    <= w_q_fix;
                    r_remainder   <= w_r_fix;
                    r_div_by_zero <= 1'b0;
                end
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=8: hand-computed results, latencies and control corner cases.
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one request (captured at edge N) and wait for done; lat = edges after N, -1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output logic busy_n);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom); is_signed = 1'($urandom);
        busy_n = busy;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("op a=%02h b=%02h s=%0d -> q=%02h r=%02h dz=%0d lat=%0d",
                 a, b, s, quotient, remainder, div_by_zero, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 5;
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (quotient !== 8'h00)   begin n_fail++; $display("FAIL reset_q got %02h want 00", quotient); end
        if (remainder !== 8'h00)  begin n_fail++; $display("FAIL reset_r got %02h want 00", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_unsigned();
        logic [W-1:0] va [3] = '{8'd100, 8'h9C, 8'hFF};
        logic [W-1:0] vb [3] = '{8'd7,   8'h07, 8'h10};
        logic [W-1:0] vq [3] = '{8'h0E,  8'h16, 8'h0F};
        logic [W-1:0] vr [3] = '{8'h02,  8'h02, 8'h0F};
        int lat;
        logic bn;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, bn);
            n_checks += 5;
            if (lat !== 8)            begin n_fail++; $display("FAIL u%0d_latency got %0d want 8", i, lat); end
            if (bn !== 1'b1)          begin n_fail++; $display("FAIL u%0d_busy got %b want 1", i, bn); end
            if (quotient !== vq[i])   begin n_fail++; $display("FAIL u%0d_q got %02h want %02h", i, quotient, vq[i]); end
            if (remainder !== vr[i])  begin n_fail++; $display("FAIL u%0d_r got %02h want %02h", i, remainder, vr[i]); end
            if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL u%0d_dz got %b want 0", i, div_by_zero); end
            @(posedge clk); #1;
            n_checks += 2;
            if (done !== 1'b0) begin n_fail++; $display("FAIL u%0d_done_width got %b want 0", i, done); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL u%0d_busy_after got %b want 0", i, busy); end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] va [4] = '{8'h9C, 8'h64, 8'h80, 8'h9C};
        logic [W-1:0] vb [4] = '{8'h07, 8'hF9, 8'hFF, 8'hF9};
        logic [W-1:0] vq [4] = '{8'hF2, 8'hF2, 8'h80, 8'h0E};
        logic [W-1:0] vr [4] = '{8'hFE, 8'h02, 8'h00, 8'hFE};
        int lat;
        logic bn;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b1, lat, bn);
            n_checks += 3;
            if (lat !== 8)           begin n_fail++; $display("FAIL s%0d_latency got %0d want 8", i, lat); end
            if (quotient !== vq[i])  begin n_fail++; $display("FAIL s%0d_q got %02h want %02h", i, quotient, vq[i]); end
            if (remainder !== vr[i]) begin n_fail++; $display("FAIL s%0d_r got %02h want %02h", i, remainder, vr[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic bn;
        run_op(8'h55, 8'h00, 1'b0, lat, bn);
        n_checks += 5;
        if (lat !== 1)            begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
        if (busy !== 1'b1)        begin n_fail++; $display("FAIL dz_busy got %b want 1", busy); end
        if (quotient !== 8'hFF)   begin n_fail++; $display("FAIL dz_q got %02h want FF", quotient); end
        if (remainder !== 8'h55)  begin n_fail++; $display("FAIL dz_r got %02h want 55", remainder); end
        if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        run_op(8'd100, 8'd7, 1'b0, lat, bn);
        n_checks += 2;
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b want 0", div_by_zero); end
        if (quotient !== 8'h0E)   begin n_fail++; $display("FAIL dz_next_q got %02h want 0E", quotient); end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd200; divisor = 8'd3; is_signed = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 5; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        $display("ignore_start q=%02h r=%02h lat=%0d", quotient, remainder, lat);
        n_checks += 3;
        if (lat !== 8)           begin n_fail++; $display("FAIL ign_latency got %0d want 8", lat); end
        if (quotient !== 8'h0E)  begin n_fail++; $display("FAIL ign_q got %02h want 0E", quotient); end
        if (remainder !== 8'h02) begin n_fail++; $display("FAIL ign_r got %02h want 02", remainder); end
        // a start presented during the done cycle must not be accepted
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks += 2;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL done_start_busy got %b want 0", busy); end
        if (quotient !== 8'h0E) begin n_fail++; $display("FAIL done_start_q got %02h want 0E", quotient); end
        $display("start during done checked");
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 8'd7; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL rmid_done got %b want 0", done); end
        if (quotient !== 8'h00)   begin n_fail++; $display("FAIL rmid_q got %02h want 00", quotient); end
        if (remainder !== 8'h00)  begin n_fail++; $display("FAIL rmid_r got %02h want 00", remainder); end
        if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rmid_dz got %b want 0", div_by_zero); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        n_checks += 2;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done got %b want 0", seen_done); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_idle got %b want 0", busy); end
        $display("reset mid-calc checked");
    endtask

    task automatic test_back_to_back();
        int lat;
        logic bn;
        run_op(8'd200, 8'd9, 1'b0, lat, bn);
        n_checks += 2;
        if (quotient !== 8'h16)  begin n_fail++; $display("FAIL b2b0_q got %02h want 16", quotient); end
        if (remainder !== 8'h02) begin n_fail++; $display("FAIL b2b0_r got %02h want 02", remainder); end
        // next request is captured at N+10, the earliest accepted edge
        run_op(8'hF6, 8'h03, 1'b1, lat, bn);
        n_checks += 3;
        if (lat !== 8)           begin n_fail++; $display("FAIL b2b1_latency got %0d want 8", lat); end
        if (quotient !== 8'hFD)  begin n_fail++; $display("FAIL b2b1_q got %02h want FD", quotient); end
        if (remainder !== 8'hFF) begin n_fail++; $display("FAIL b2b1_r got %02h want FF", remainder); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
